// File: rtl/fpu_csr_bank_if.sv
// CSR request/response bus between the CSR unit (master) and the per-warp FP CSR bank (slave).
interface fpu_csr_bank_if #(
  parameter int NW_BITS   = 2,
  parameter int DATA_BITS = 8
);
  // valid/ready: a request transfers on a cycle where csr_req_valid && csr_req_ready;
  // ready never depends on valid, and responses have no backpressure.
  logic                 csr_req_valid;
  logic                 csr_req_ready;
  logic [NW_BITS-1:0]   csr_req_wid;
  logic [1:0]           csr_req_addr;
  logic                 csr_req_write;
  logic [DATA_BITS-1:0] csr_req_wdata;
  logic                 csr_rsp_valid;
  logic [DATA_BITS-1:0] csr_rsp_data;

  modport master (
    output csr_req_valid, csr_req_wid, csr_req_addr, csr_req_write, csr_req_wdata,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_data
  );

  modport slave (
    input  csr_req_valid, csr_req_wid, csr_req_addr, csr_req_write, csr_req_wdata,
    output csr_req_ready, csr_rsp_valid, csr_rsp_data
  );
endinterface

// File: rtl/fpu_csr_bank.sv
// Per-warp sticky fflags and frm storage, merging FPU writebacks and gating CSR
// fflags/fcsr accesses until the warp's in-flight FPU operations have retired.
module fpu_csr_bank #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_WR_PORTS = 2,
  parameter int MAX_PENDING  = 7,
  parameter int FFLAGS_BITS  = 5,
  parameter int FRM_BITS     = 3,
  parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int PB           = $clog2(MAX_PENDING + 1),
  parameter int DATA_BITS    = FRM_BITS + FFLAGS_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                issue_valid,
  input  logic [NW_BITS-1:0]                  issue_wid,
  output logic                                issue_ready,
  input  logic [NUM_WR_PORTS-1:0]             wr_enable,
  input  logic [NUM_WR_PORTS*NW_BITS-1:0]     wr_wid,
  input  logic [NUM_WR_PORTS*FFLAGS_BITS-1:0] wr_fflags,
  input  logic [NW_BITS-1:0]                  read_wid,
  output logic [FRM_BITS-1:0]                 read_frm,
  fpu_csr_bank_if.slave                       csr,
  output logic                                err_underflow
);

  logic [FFLAGS_BITS-1:0] fflags_q [NUM_WARPS];
  logic [FFLAGS_BITS-1:0] fflags_d [NUM_WARPS];
  logic [FRM_BITS-1:0]    frm_q    [NUM_WARPS];
  logic [FRM_BITS-1:0]    frm_d    [NUM_WARPS];
  logic [PB-1:0]          pending_q[NUM_WARPS];
  logic [PB-1:0]          pending_d[NUM_WARPS];
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0]   rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  logic                   req_fire;
  logic [DATA_BITS-1:0]   rd_value;
  logic [FFLAGS_BITS-1:0] wb_flags;
  int                     up_cnt;
  int                     wb_cnt;

  assign issue_ready       = (pending_q[issue_wid] != PB'(MAX_PENDING));
  assign csr.csr_req_ready = (csr.csr_req_addr == 2'd1) || (pending_q[csr.csr_req_wid] == '0);
  assign req_fire          = csr.csr_req_valid && csr.csr_req_ready;
  assign read_frm          = frm_q[read_wid];
  assign csr.csr_rsp_valid = rsp_valid_q;
  assign csr.csr_rsp_data  = rsp_data_q;
  assign err_underflow     = err_q;

  always_comb begin
    rd_value = '0;
    case (csr.csr_req_addr)
      2'd0:    rd_value = DATA_BITS'(fflags_q[csr.csr_req_wid]);
      2'd1:    rd_value = DATA_BITS'(frm_q[csr.csr_req_wid]);
      2'd2:    rd_value = {frm_q[csr.csr_req_wid], fflags_q[csr.csr_req_wid]};
      default: rd_value = '0;
    endcase
  end

  always_comb begin
    fflags_d    = fflags_q;
    frm_d       = frm_q;
    pending_d   = pending_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    wb_flags    = '0;
    up_cnt      = 0;
    wb_cnt      = 0;

    if (req_fire && !csr.csr_req_write) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_value;
    end

    // The CSR write lands first so same-cycle writeback flags are ORed on top of it.
    if (req_fire && csr.csr_req_write) begin
      if (csr.csr_req_addr == 2'd0 || csr.csr_req_addr == 2'd2)
        fflags_d[csr.csr_req_wid] = csr.csr_req_wdata[FFLAGS_BITS-1:0];
      if (csr.csr_req_addr == 2'd1)
        frm_d[csr.csr_req_wid] = csr.csr_req_wdata[FRM_BITS-1:0];
      if (csr.csr_req_addr == 2'd2)
        frm_d[csr.csr_req_wid] = csr.csr_req_wdata[DATA_BITS-1:FFLAGS_BITS];
    end

    for (int w = 0; w < NUM_WARPS; w++) begin
      wb_flags = '0;
      wb_cnt   = 0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_enable[p] && (wr_wid[p*NW_BITS +: NW_BITS] == NW_BITS'(w))) begin
          wb_flags = wb_flags | wr_fflags[p*FFLAGS_BITS +: FFLAGS_BITS];
          wb_cnt   = wb_cnt + 1;
        end
      end
      fflags_d[w] = fflags_d[w] | wb_flags;
      up_cnt = int'(pending_q[w]);
      if (issue_valid && issue_ready && (issue_wid == NW_BITS'(w)))
        up_cnt = up_cnt + 1;
      if (wb_cnt > up_cnt) begin
        pending_d[w] = '0;
        err_d        = 1'b1;
      end else begin
        pending_d[w] = PB'(up_cnt - wb_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w]  <= '0;
        frm_q[w]     <= '0;
        pending_q[w] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      fflags_q    <= fflags_d;
      frm_q       <= frm_d;
      pending_q   <= pending_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/fpu_csr_bank.md
Name: fpu_csr_bank

Overview:
- Per-warp floating-point CSR storage shared by the FPU and the CSR unit.
- Holds sticky fflags (accumulated by OR) and frm for each of NUM_WARPS warps.
- Merges NUM_WR_PORTS FPU fflags writebacks per cycle.
- Tracks in-flight FPU operations per warp, so CSR reads and writes of fflags/fcsr wait until that warp's pending operations have retired.

Parameters:
- NUM_WARPS, 4, number of warps; NW_BITS = max(1, clog2(NUM_WARPS)).
- NUM_WR_PORTS, 2, FPU fflags writeback ports per cycle.
- MAX_PENDING, 7, maximum in-flight FPU operations per warp; PB = clog2(MAX_PENDING+1).
- FFLAGS_BITS, 5, fflags width (NV,DZ,OF,UF,NX).
- FRM_BITS, 3, rounding-mode width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- issue_valid, input, 1, FPU operation issued for issue_wid.
- issue_wid, input, NW_BITS, issuing warp.
- issue_ready, output, 1, low while pending[issue_wid]==MAX_PENDING.
- wr_enable, input, NUM_WR_PORTS, per-port fflags writeback valid; each writeback retires one operation.
- wr_wid, input, NUM_WR_PORTS*NW_BITS, per-port warp.
- wr_fflags, input, NUM_WR_PORTS*FFLAGS_BITS, per-port flags.
- read_wid, input, NW_BITS, FPU frm lookup warp.
- read_frm, output, FRM_BITS, frm[read_wid]; combinational, no same-cycle bypass.
- csr_req_valid, input, 1, CSR access request.
- csr_req_ready, output, 1, request accepted when high together with valid.
- csr_req_wid, input, NW_BITS, target warp.
- csr_req_addr, input, 2, target field: 0=fflags, 1=frm, 2=fcsr ({frm,fflags}), 3=reserved.
- csr_req_write, input, 1, 1=write, 0=read.
- csr_req_wdata, input, FRM_BITS+FFLAGS_BITS, write data.
- csr_rsp_valid, output, 1, read response valid.
- csr_rsp_data, output, FRM_BITS+FFLAGS_BITS, read data, zero-extended.
- err_underflow, output, 1, sticky: writeback arrived for a warp with zero pending.

Behaviour:
- Reset (asynchronous, reset==0):
  - All fflags, frm and pending counters are cleared to 0.
  - csr_rsp_valid=0, csr_rsp_data=0, err_underflow=0.
  - Applies immediately, mid-operation included; in-flight responses are dropped.
- Issue:
  - issue_valid && issue_ready increments pending[issue_wid] at the clock edge.
  - issue_valid while issue_ready is low is ignored; the producer must hold the request.
- Writeback:
  - Each enabled port ORs its wr_fflags into fflags[wr_wid] and decrements pending[wr_wid] by 1.
  - Several ports hitting the same warp: flags are OR-merged; the decrement equals the number of such ports.
- Net counter update per warp per cycle: pending + issue − writebacks, all computed in one cycle.
- Underflow:
  - A writeback that would take the count below 0 saturates the counter at 0 and sets err_underflow.
  - Flags from that writeback are still ORed in.
- CSR ready:
  - csr_req_ready = (csr_req_addr==1) || (pending[csr_req_wid]==0).
  - frm accesses are never blocked; fflags and fcsr accesses wait for pending==0.
  - Combinational, with no dependence on csr_req_valid.
- CSR read:
  - An accepted read registers csr_rsp_valid=1 on the next edge.
  - csr_rsp_data holds the pre-edge value: fflags, frm, or {frm,fflags}; reserved address returns 0.
  - csr_rsp_valid stays high for exactly one cycle; there is no backpressure, so back-to-back reads give consecutive responses.
- CSR write:
  - An accepted write updates storage at the edge.
  - addr 0 writes the low FFLAGS_BITS; addr 1 writes wdata[FRM_BITS-1:0]; addr 2 writes both fields.
  - Reserved address: no effect.
  - A write produces no response.
- Same-cycle CSR write and FPU writeback to the same warp: the CSR value is the base and the writeback flags are ORed on top, so no flags are lost.
- read_frm reflects a CSR frm write from the cycle after the write edge.
- Pending-counter wrap is impossible: issue is gated at MAX_PENDING.

Test Plan:
- Reset, then CSR read of fcsr for warp 2 → csr_rsp_valid the following cycle, data 0x00; read_frm=0 for all warps.
- CSR write frm=3'b011 to warp 1; set read_wid=1 → read_frm=3 from the next cycle; fcsr read on warp 1 returns 0x60.
- Issue 2 ops on warp 0; CSR fflags read → csr_req_ready=0; wr port0 flags 0x01 and port1 flags 0x10, both warp 0, same cycle → pending reaches 0, csr_req_ready=1, read returns 0x11.
- Issue 7 ops on warp 3 → issue_ready=0 on warp 3 and the 8th issue is ignored; one writeback → issue_ready=1.
- CSR fflags write 0x04 to warp 2 in the same cycle as a writeback of 0x01 to warp 2 → read returns 0x05; a writeback with pending 0 sets err_underflow=1.
- Assert reset while a read is in flight and pending[0]=3 → csr_rsp_valid=0 immediately; after release, pending[0]=0 and fflags=0.
